// File: rtl/rr_arb_2to1_pkg.sv
// Shared types and constants for the 2:1 round-robin arbiter.
package rr_arb_2to1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A  = 1'b0;
    localparam logic SEL_B  = 1'b1;

    // Priority pointer encoding: which source wins a simultaneous request.
    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

endpackage

// File: rtl/rr_arb_2to1_burst_cnt.sv
// Per-grant burst counter; saturates at MAX-1 so it can never wrap.
module burst_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic max_hit
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign max_hit = (cnt_q == LIMIT);

endmodule

// File: rtl/rr_arb_2to1.sv
// Two-source round-robin arbiter with burst limit and registered mux select.
// Handshake: a source holds req high while it wants the path; its grant appears
// one edge later and is released on req low, last high, or burst limit.
module rr_arb_2to1
    import rr_arb_2to1_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       last,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       sel,
    output logic       busy,
    output logic [1:0] state_dbg
);

    arb_state_e state_q, state_d;
    logic       prio_q, prio_d;
    logic       sel_q, sel_d;
    logic       max_hit;
    logic       rel;
    logic       enter_grant;
    logic       cnt_clr;
    logic       cnt_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= PRIO_A;
            sel_q   <= SEL_A;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rel         = 1'b0;
        enter_grant = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = (prio_q == PRIO_A) ? GNT_A : GNT_B;
                end else if (req_a) begin
                    state_d = GNT_A;
                end else if (req_b) begin
                    state_d = GNT_B;
                end
                enter_grant = (state_d != IDLE);
            end
            GNT_A: begin
                rel = !req_a || last || max_hit;
                if (rel) begin
                    // The other source wins on release; a lone holder is re-granted.
                    if (req_b)      state_d = GNT_B;
                    else if (req_a) state_d = GNT_A;
                    else            state_d = IDLE;
                    enter_grant = (state_d != IDLE);
                end
            end
            GNT_B: begin
                rel = !req_b || last || max_hit;
                if (rel) begin
                    if (req_a)      state_d = GNT_A;
                    else if (req_b) state_d = GNT_B;
                    else            state_d = IDLE;
                    enter_grant = (state_d != IDLE);
                end
            end
            default: state_d = IDLE;
        endcase

        prio_d = prio_q;
        if (enter_grant && (state_d == GNT_A)) prio_d = PRIO_B;
        if (enter_grant && (state_d == GNT_B)) prio_d = PRIO_A;

        // Select holds its last value through IDLE so the mux output stays stable.
        sel_d = sel_q;
        if (state_d == GNT_A) sel_d = SEL_A;
        if (state_d == GNT_B) sel_d = SEL_B;
    end

    always_comb begin
        gnt_a     = (state_q == GNT_A);
        gnt_b     = (state_q == GNT_B);
        busy      = gnt_a || gnt_b;
        sel       = sel_q;
        state_dbg = state_q;
    end

    assign cnt_clr = enter_grant || (state_d == IDLE);
    assign cnt_en  = (state_q != IDLE) && !cnt_clr;

    burst_cnt #(
        .MAX(MAX_BURST)
    ) u_burst (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .max_hit(max_hit)
    );

endmodule

// File: tb/tb_rr_arb_2to1.sv
// Directed bench for rr_arb_2to1: vector table on a MAX_BURST=4 instance, plus
// hand sequences for async reset and a MAX_BURST=1 instance.
module tb_rr_arb_2to1;

  typedef struct {
    logic ra;
    logic rb;
    logic lst;
    logic ga;
    logic gb;
    logic s;
    logic b;
    int   cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic req_a = 1'b0, req_b = 1'b0, last = 1'b0;
  logic gnt_a, gnt_b, sel, busy;
  logic [1:0] state_dbg;

  logic req1_a = 1'b0, req1_b = 1'b0, last1 = 1'b0;
  logic gnt1_a, gnt1_b, sel1, busy1;
  logic [1:0] state1_dbg;

  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  rr_arb_2to1 #(.MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .last(last),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .busy(busy), .state_dbg(state_dbg)
  );

  rr_arb_2to1 #(.MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req1_a), .req_b(req1_b), .last(last1),
    .gnt_a(gnt1_a), .gnt_b(gnt1_b), .sel(sel1), .busy(busy1), .state_dbg(state1_dbg)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ra, input logic rb, input logic lst, input logic ga,
                     input logic gb, input logic s, input logic b, input int cnt);
    vec_t v;
    v.ra = ra; v.rb = rb; v.lst = lst; v.ga = ga; v.gb = gb; v.s = s; v.b = b; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Grants must be mutually exclusive on both instances at every sample point.
  always @(negedge clk) begin
    if (rst_n) begin
      check("mutex4", int'(gnt_a && gnt_b), 0);
      check("mutex1", int'(gnt1_a && gnt1_b), 0);
    end
  end

  initial begin
    logic y;
    #1;
    check("rst_gnt_a", gnt_a, 0);
    check("rst_gnt_b", gnt_b, 0);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both requesting: 4 A, 4 B, then A again; then drop both.
    for (int i = 0; i < 4; i++) add(1, 1, 0, 1, 0, 0, 1, i);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 1, 1, 1, i);
    add(1, 1, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // B alone, ends with last; sel holds 1 in IDLE.
    add(0, 1, 0, 0, 1, 1, 1, 0);
    add(0, 1, 0, 0, 1, 1, 1, 1);
    add(0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    // A alone for 10 cycles: re-granted with counter cleared every 4.
    for (int i = 0; i < 10; i++) add(1, 0, 0, 1, 0, 0, 1, i % 4);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // Pointer now favours B; last forces switch, then lone re-grant of A.
    add(1, 1, 0, 0, 1, 1, 1, 0);
    add(1, 1, 1, 1, 0, 0, 1, 0);
    add(1, 1, 0, 1, 0, 0, 1, 1);
    add(1, 0, 1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      req_a = vecs[i].ra;
      req_b = vecs[i].rb;
      last  = vecs[i].lst;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_gnt_a", i), gnt_a, vecs[i].ga);
      check($sformatf("v%0d_gnt_b", i), gnt_b, vecs[i].gb);
      check($sformatf("v%0d_sel", i), sel, vecs[i].s);
      check($sformatf("v%0d_busy", i), busy, vecs[i].b);
      check($sformatf("v%0d_cnt", i), int'(u_dut4.u_burst.cnt_q), vecs[i].cnt);
      // Downstream mux with A=1, B=0.
      y = sel ? 1'b0 : 1'b1;
      if (vecs[i].b) check($sformatf("v%0d_mux_y", i), y, vecs[i].ga);
    end

    // Async reset in the middle of a GNT_B cycle.
    req_a = 1'b0; req_b = 1'b1; last = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_gnt_b", gnt_b, 1);
    check("pre_rst_sel", sel, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt_b", gnt_b, 0);
    check("async_busy", busy, 0);
    check("async_sel", sel, 0);
    check("async_state", state_dbg, 0);
    req_a = 1'b1; req_b = 1'b1;
    @(posedge clk);
    #1;
    check("in_rst_gnt_a", gnt_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_gnt_a", gnt_a, 1);
    check("post_rst_gnt_b", gnt_b, 0);
    req_a = 1'b0; req_b = 1'b0;

    // MAX_BURST=1: single-cycle grants alternating, A first after reset.
    req1_a = 1'b1; req1_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("mb1_%0d_gnt_a", i), gnt1_a, (i % 2 == 0) ? 1 : 0);
      check($sformatf("mb1_%0d_gnt_b", i), gnt1_b, (i % 2 == 1) ? 1 : 0);
      check($sformatf("mb1_%0d_sel", i), sel1, (i % 2 == 1) ? 1 : 0);
    end
    req1_a = 1'b0; req1_b = 1'b0;
    @(posedge clk);
    #1;
    check("mb1_idle_busy", busy1, 0);
    check("mb1_idle_sel", sel1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
